// File: rtl/uart_led_ctrl.sv
// uart_led_ctrl: 8N1 UART receiver that decodes single-byte commands
// into a registered 4-bit LED pattern. Unknown bytes and frames with a
// bad stop bit leave the LEDs untouched.
module uart_led_ctrl #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst_n,   // synchronous, active-high despite the name
    input  logic       rx,
    output logic [3:0] led_out
);

    localparam int unsigned BIT_CNT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W   = $clog2(BIT_CNT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BIT_CNT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BIT_CNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_valid_q, byte_valid_d;
    logic [3:0]       led_q, led_d;

    logic rx_meta_q, rx_sync_q, rx_prev_q;
    logic fall_edge;

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    // Reset loads the idle level so release never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the old
            // value of its neighbour, which is what builds a real shift chain.
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // A start is only recognised on a 1->0 transition, so a line held low
    // after a framing error cannot re-trigger until it has returned high.
    assign fall_edge = rx_prev_q & ~rx_sync_q;

    // Receiver state, timing and data registers.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
        end
    end

    // Receiver next-state: half a bit to the start-bit centre, then one full
    // bit per sample for the eight data bits and the stop bit.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a signal unassigned and no latch is inferred.
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (fall_edge) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    // High at mid start bit means the edge was a glitch.
                    state_d   = rx_sync_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    // LSB arrives first and ends up in bit 0 after eight shifts.
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d        = '0;
                    state_d      = IDLE;
                    // A low stop bit is a framing error: the byte is dropped.
                    byte_valid_d = rx_sync_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Command decode: recognised bytes load a pattern, anything else holds.
    always_comb begin
        led_d = led_q;
        if (byte_valid_q) begin
            case (shift_q)
                8'hAA:   led_d = 4'b0001;
                8'hBB:   led_d = 4'b0010;
                8'hCC:   led_d = 4'b0100;
                8'hDD:   led_d = 4'b1000;
                8'h55:   led_d = 4'b0000;
                8'h66:   led_d = 4'b1111;
                8'h77:   led_d = 4'b1010;
                8'h88:   led_d = 4'b0101;
                default: led_d = led_q;
            endcase
        end
    end

    // LED output register.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            led_q <= 4'b0000;
        end else begin
            led_q <= led_d;
        end
    end

    assign led_out = led_q;

endmodule

// File: tb/tb_uart_led_ctrl.sv
// tb_uart_led_ctrl: drives UART frames into uart_led_ctrl; expected LED
// changes are queued by the stimulus and consumed by an independent monitor.
`timescale 1ns/1ps
module tb_uart_led_ctrl;

    // 64 clocks per bit keeps the run short while leaving ample timing margin.
    localparam int unsigned CLK_FREQ = 50_000_000;
    localparam int unsigned BAUD     = 781_250;
    localparam int          BIT_NS   = 1282;   // nominal 1280 ns, slightly slow
    localparam int          FAST_NS  = 1254;   // -2 %
    localparam int          SLOW_NS  = 1306;   // +2 %

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx    = 1'b1;
    logic [3:0] led_out;

    uart_led_ctrl #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rx     (rx),
        .led_out(led_out)
    );

    always #10 clk = ~clk;

    logic [3:0] exp_q[$];
    logic [3:0] exp_led;
    logic [3:0] last_led;
    bit         mon_en = 1'b0;
    int         checks = 0;
    int         failures = 0;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: led_out=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every change of led_out must match the next queued expectation.
    always @(negedge clk) begin
        if (mon_en && (led_out !== last_led)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_change", led_out, last_led);
            end else begin
                check("led_change", led_out, exp_q.pop_front());
            end
            last_led = led_out;
        end
    end

    task automatic send_frame(input logic [7:0] b, input int bit_ns, input logic stop_bit);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_ns);
        end
        rx = stop_bit;
        #(bit_ns);
        rx = 1'b1;
    endtask

    // Queue the hand-computed result (only if the LEDs should visibly change),
    // send the frame and leave one idle bit afterwards.
    task automatic send_cmd(input logic [7:0] b, input logic [3:0] exp_after, input int bit_ns);
        if (exp_after !== exp_led) begin
            exp_q.push_back(exp_after);
            exp_led = exp_after;
        end
        send_frame(b, bit_ns, 1'b1);
        #(bit_ns);
    endtask

    // Wait (bounded) for all queued changes to be seen, then confirm the level.
    task automatic sync_check(input string name);
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: %0d expected changes never seen", name, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        check(name, led_out, exp_led);
    endtask

    logic [7:0] seq_b [9] = '{8'hBB, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h55, 8'h66, 8'h77, 8'h88};
    logic [3:0] seq_e [9] = '{4'b0010, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                              4'b0000, 4'b1111, 4'b1010, 4'b0101};

    initial begin
        logic [7:0] abort_b;

        // Reset with idle line, then check the idle state holds.
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_led", led_out, 4'b0000);
        exp_led  = 4'b0000;
        last_led = led_out;
        mon_en   = 1'b1;
        repeat (200) @(negedge clk);
        sync_check("idle_quiet");

        // Single commands.
        send_cmd(8'hBB, 4'b0010, BIT_NS);
        send_cmd(8'hAA, 4'b0001, BIT_NS);
        sync_check("single_cmd");

        // Full command sequence with one idle bit between frames.
        for (int i = 0; i < 9; i++) begin
            send_cmd(seq_b[i], seq_e[i], BIT_NS);
        end
        sync_check("sequence");

        // Unrecognised byte holds the previous pattern.
        send_cmd(8'hDD, 4'b1000, BIT_NS);
        send_cmd(8'h12, 4'b1000, BIT_NS);
        sync_check("unrecognised");

        // Short low glitch on an idle line is rejected at mid start bit.
        rx = 1'b0;
        #80;
        rx = 1'b1;
        #(BIT_NS * 2);
        sync_check("glitch");

        // Framing error: stop bit low, byte discarded; next frame still decodes.
        send_frame(8'hCC, BIT_NS, 1'b0);
        #(BIT_NS);
        sync_check("framing_error");
        send_cmd(8'h66, 4'b1111, BIT_NS);
        sync_check("after_framing");

        // Reset in the middle of bit4 of 0xAA: LEDs clear, frame is lost.
        abort_b = 8'hAA;
        exp_q.push_back(4'b0000);
        exp_led = 4'b0000;
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rx = abort_b[i];
            #(BIT_NS);
        end
        rx = abort_b[4];
        #(BIT_NS / 2);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #(BIT_NS * 2);
        sync_check("reset_mid_frame");
        send_cmd(8'hBB, 4'b0010, BIT_NS);
        sync_check("after_reset");

        // Baud error at both ends of the tolerance window.
        send_cmd(8'h77, 4'b1010, SLOW_NS);
        send_cmd(8'h88, 4'b0101, FAST_NS);
        sync_check("baud_tolerance");

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

endmodule
